// File: rtl/line_clear_ctrl_if.sv
// Handshake and row-array bus between the game FSM, the line-clear sequencer and the row registers.
// The master side is the sequencer; the slave side is the FSM plus row array.
interface line_clear_ctrl_if #(
  parameter int ROWS = 20,
  parameter int CW   = 5
);
  logic            start;
  logic [ROWS-1:0] full;
  logic [2:0]      row_state;
  logic [ROWS-1:0] shift_row;
  logic            busy;
  logic            done;
  logic [CW-1:0]   lines;
  logic [15:0]     total_lines;

  modport master (
    input  start, full,
    output row_state, shift_row, busy, done, lines, total_lines
  );

  modport slave (
    output start, full,
    input  row_state, shift_row, busy, done, lines, total_lines
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: check rows, shift everything above the lowest full row down,
// repeat until no full row remains, then report the number of lines removed.
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int CW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  line_clear_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHK1  = 3'd1,
    CHK2  = 3'd2,
    SCAN  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [2:0] RS_CHECK = 3'b000;
  localparam logic [2:0] RS_MOVE  = 3'b001;
  localparam logic [2:0] RS_SHIFT = 3'b011;

  state_t          state_q, state_d;
  logic [ROWS-1:0] full_q, full_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      row_state_q, row_state_d;
  logic [ROWS-1:0] shift_row_q, shift_row_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   lines_q, lines_d;
  logic [15:0]     total_q, total_d;

  logic [ROWS-1:0] scan_mask;
  logic            scan_acc;
  logic [16:0]     total_sum;

  // Suffix-OR: bit i is set when any row at index >= i is full, which is exactly
  // the set of rows at or above the bottom-most full row.
  always_comb begin
    scan_acc  = 1'b0;
    scan_mask = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      scan_acc     = scan_acc | full_q[i];
      scan_mask[i] = scan_acc;
    end
  end

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    count_d     = count_q;
    row_state_d = RS_MOVE;
    shift_row_d = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    lines_d     = lines_q;
    total_d     = total_q;
    total_sum   = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          count_d = '0;
          state_d = CHK1;
        end
      end
      CHK1: state_d = CHK2;
      CHK2: begin
        full_d  = bus.full;
        state_d = SCAN;
      end
      SCAN: begin
        if (full_q == '0) begin
          state_d = DONE;
        end else begin
          shift_row_d = scan_mask;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q != '1) count_d = count_q + CW'(1);
        state_d = CHK1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    case (state_d)
      CHK1, CHK2: row_state_d = RS_CHECK;
      SHIFT:      row_state_d = RS_SHIFT;
      default:    row_state_d = RS_MOVE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

    if (state_d == DONE) begin
      lines_d   = count_d;
      total_sum = {1'b0, total_q} + 17'(count_d);
      total_d   = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      full_q      <= '0;
      count_q     <= '0;
      row_state_q <= RS_MOVE;
      shift_row_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lines_q     <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      count_q     <= count_d;
      row_state_q <= row_state_d;
      shift_row_q <= shift_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lines_q     <= lines_d;
      total_q     <= total_d;
    end
  end

  assign bus.row_state   = row_state_q;
  assign bus.shift_row   = shift_row_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.lines       = lines_q;
  assign bus.total_lines = total_q;

endmodule
